// File: rtl/trace_pkg.sv
// Shared types, default widths and the round-robin helper for the trace merge arbiter.
//   trace_entry_t : {record, source, timestamp} at the default configuration
//   next_rr()     : index of the first requester after 'pointer', wrapping at num_sources
package trace_pkg;

  localparam int unsigned DEF_NUM_SOURCES       = 2;
  localparam int unsigned DEF_RECORD_WIDTH      = 48;
  localparam int unsigned DEF_HOLD_DEPTH        = 2;
  localparam int unsigned DEF_TRACE_BUFFER_SIZE = 8;
  localparam int unsigned DEF_DROP_CNT_WIDTH    = 16;
  localparam int unsigned DEF_SRC_W             = 1;
  localparam int unsigned TIME_W                = 32;
  localparam int unsigned MAX_SOURCES           = 8;
  localparam int unsigned RR_IDX_W              = 3;

  typedef struct packed {
    logic [DEF_RECORD_WIDTH-1:0] record;
    logic [DEF_SRC_W-1:0]        source;
    logic [TIME_W-1:0]           timestamp;
  } trace_entry_t;

  // Search starts one past the last grant so every requester is reached within num_sources turns.
  // Returns 'pointer' unchanged when nothing requests; the caller qualifies with |request_mask.
  function automatic logic [RR_IDX_W-1:0] next_rr(
    input logic [RR_IDX_W-1:0]    pointer,
    input logic [MAX_SOURCES-1:0] request_mask,
    input int unsigned            num_sources
  );
    logic [RR_IDX_W-1:0] idx;
    logic                found;
    int unsigned         cand;
    idx   = pointer;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_SOURCES; k++) begin
      cand = (32'(pointer) + k) % num_sources;
      if (!found && (k <= num_sources) && request_mask[cand[RR_IDX_W-1:0]]) begin
        idx   = cand[RR_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/trace_merge_arbiter_if.sv
// Bus bundle for the trace merge arbiter.
//   source side : counter, enable, src_valid, src_record (pulse, no backpressure)
//   sink side   : trace_valid/trace_ready handshake with trace_record/source/time payload
//   status      : drop_count, overflow
// slave = arbiter view, master = producer/sink environment view.
interface trace_merge_arbiter_if #(
  parameter int unsigned NUM_SOURCES    = trace_pkg::DEF_NUM_SOURCES,
  parameter int unsigned RECORD_WIDTH   = trace_pkg::DEF_RECORD_WIDTH,
  parameter int unsigned DROP_CNT_WIDTH = trace_pkg::DEF_DROP_CNT_WIDTH
);
  localparam int unsigned SRC_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  logic [31:0]                          counter;
  logic                                 enable;
  logic [NUM_SOURCES-1:0]               src_valid;
  logic [NUM_SOURCES*RECORD_WIDTH-1:0]  src_record;
  logic                                 trace_valid;
  logic                                 trace_ready;
  logic [RECORD_WIDTH-1:0]              trace_record;
  logic [SRC_W-1:0]                     trace_source;
  logic [31:0]                          trace_time;
  logic [DROP_CNT_WIDTH-1:0]            drop_count;
  logic                                 overflow;

  modport master (
    output counter, enable, src_valid, src_record, trace_ready,
    input  trace_valid, trace_record, trace_source, trace_time, drop_count, overflow
  );

  modport slave (
    input  counter, enable, src_valid, src_record, trace_ready,
    output trace_valid, trace_record, trace_source, trace_time, drop_count, overflow
  );

endinterface

// File: rtl/trace_fifo.sv
// Show-ahead synchronous FIFO.
//   push/push_data : write when not full, or when full and popping in the same cycle
//   pop/pop_data   : pop_data always shows the head; pop ignored when empty
//   full/empty/count : from the registered count (one bit wider than the pointers)
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer and occupancy update; a pop frees the slot a same-cycle push reuses.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/trace_merge_arbiter.sv
// Merges pulsed trace records from NUM_SOURCES trackers into one timestamped stream.
//   clk, rst : posedge clock, synchronous active-high reset
//   bus      : slave view of trace_merge_arbiter_if (source pulses in, valid/ready stream out,
//              saturating drop counter and sticky overflow)
// Each source lands in its own holding FIFO; a round-robin arbiter moves at most one entry
// per cycle into the shared output FIFO, which the sink drains show-ahead.
module trace_merge_arbiter
  import trace_pkg::*;
#(
  parameter int unsigned NUM_SOURCES       = DEF_NUM_SOURCES,
  parameter int unsigned RECORD_WIDTH      = DEF_RECORD_WIDTH,
  parameter int unsigned HOLD_DEPTH        = DEF_HOLD_DEPTH,
  parameter int unsigned TRACE_BUFFER_SIZE = DEF_TRACE_BUFFER_SIZE,
  parameter int unsigned DROP_CNT_WIDTH    = DEF_DROP_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  trace_merge_arbiter_if.slave bus
);

  localparam int unsigned SRC_W   = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int unsigned ENTRY_W = RECORD_WIDTH + SRC_W + TIME_W;
  localparam int unsigned OCNT_W  = $clog2(TRACE_BUFFER_SIZE) + 1;
  localparam int unsigned DSUM_W  = DROP_CNT_WIDTH + 1;
  localparam int unsigned DNUM_W  = $clog2(MAX_SOURCES + 1);

  typedef struct packed {
    logic [RECORD_WIDTH-1:0] record;
    logic [SRC_W-1:0]        source;
    logic [TIME_W-1:0]       timestamp;
  } entry_t;

  logic [NUM_SOURCES-1:0]    cap_valid;
  logic [NUM_SOURCES-1:0]    hold_push;
  logic [NUM_SOURCES-1:0]    hold_pop;
  logic [NUM_SOURCES-1:0]    hold_full;
  logic [NUM_SOURCES-1:0]    hold_empty;
  logic [NUM_SOURCES-1:0]    req_mask;
  logic [NUM_SOURCES-1:0]    drop_vec;
  entry_t                    hold_in  [NUM_SOURCES];
  entry_t                    hold_out [NUM_SOURCES];

  logic [SRC_W-1:0]          rr_q, rr_d;
  logic [SRC_W-1:0]          grant_idx;
  logic                      grant_valid;
  entry_t                    grant_entry;

  entry_t                    out_head;
  logic                      out_empty;
  logic                      out_full_unused;
  logic                      out_pop;
  logic [OCNT_W-1:0]         out_count;

  logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic                      overflow_q, overflow_d;
  logic [DNUM_W-1:0]         drop_num;
  logic [DSUM_W-1:0]         drop_sum;

  assign cap_valid = {NUM_SOURCES{bus.enable}} & bus.src_valid;

  // Per-source holding FIFOs; the entry is stamped with the counter of the capture cycle.
  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_hold
    logic [$clog2(HOLD_DEPTH):0] count_unused;

    assign hold_in[i] = {bus.src_record[i*RECORD_WIDTH +: RECORD_WIDTH], SRC_W'(i), bus.counter};

    trace_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (HOLD_DEPTH)
    ) u_hold (
      .clk       (clk),
      .rst       (rst),
      .push      (hold_push[i]),
      .push_data (hold_in[i]),
      .pop       (hold_pop[i]),
      .pop_data  (hold_out[i]),
      .full      (hold_full[i]),
      .empty     (hold_empty[i]),
      .count     (count_unused)
    );
  end

  // Arbitration and capture/drop decisions. Space is judged on the registered output count,
  // so a same-cycle sink pop never opens a slot for this cycle's transfer.
  always_comb begin
    req_mask    = ~hold_empty;
    grant_idx   = SRC_W'(next_rr(RR_IDX_W'(rr_q), MAX_SOURCES'(req_mask), NUM_SOURCES));
    grant_valid = (|req_mask) && (out_count < OCNT_W'(TRACE_BUFFER_SIZE));
    grant_entry = hold_out[grant_idx];
    hold_pop    = '0;
    if (grant_valid) begin
      hold_pop[grant_idx] = 1'b1;
    end
    // A full holding FIFO still accepts when it is being drained this very cycle.
    hold_push = cap_valid & (~hold_full | hold_pop);
    drop_vec  = cap_valid & hold_full & ~hold_pop;
    rr_d      = grant_valid ? grant_idx : rr_q;
  end

  // Drop accounting: several sources may drop in one cycle; the sum saturates at all-ones.
  always_comb begin
    drop_num = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      drop_num = drop_num + DNUM_W'(drop_vec[i]);
    end
    drop_sum     = {1'b0, drop_count_q} + DSUM_W'(drop_num);
    drop_count_d = drop_sum[DROP_CNT_WIDTH] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
    overflow_d   = overflow_q | (|drop_vec);
  end

  assign out_pop = !out_empty && bus.trace_ready;

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (TRACE_BUFFER_SIZE)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .push      (grant_valid),
    .push_data (grant_entry),
    .pop       (out_pop),
    .pop_data  (out_head),
    .full      (out_full_unused),
    .empty     (out_empty),
    .count     (out_count)
  );

  // Pointer and status registers; reset pointer makes source 0 the first winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q         <= SRC_W'(NUM_SOURCES - 1);
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Head payload is forced to zero while empty so stale storage never leaks out.
  always_comb begin
    bus.trace_valid  = !out_empty;
    bus.trace_record = out_empty ? '0 : out_head.record;
    bus.trace_source = out_empty ? '0 : out_head.source;
    bus.trace_time   = out_empty ? '0 : out_head.timestamp;
  end

  assign bus.drop_count = drop_count_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_trace_merge_arbiter.sv
module tb_trace_merge_arbiter;
  import trace_pkg::*;

  localparam int unsigned NS   = 2;
  localparam int unsigned RW   = 48;
  localparam int unsigned HD   = 2;
  localparam int unsigned TBS  = 8;
  localparam int unsigned DW   = 16;
  localparam longint      DMAX = 65535;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trace_merge_arbiter_if #(.NUM_SOURCES(NS), .RECORD_WIDTH(RW), .DROP_CNT_WIDTH(DW)) bus ();

  trace_merge_arbiter #(
    .NUM_SOURCES(NS), .RECORD_WIDTH(RW), .HOLD_DEPTH(HD),
    .TRACE_BUFFER_SIZE(TBS), .DROP_CNT_WIDTH(DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;

  // Reference model: queues per holding buffer and for the output buffer.
  trace_entry_t m_hold [NS][$];
  trace_entry_t m_out  [$];
  int           m_rr;
  longint       m_raw;
  bit           m_ovf;

  function automatic logic [RW-1:0] rand_rec();
    return RW'({$urandom(), $urandom()});
  endfunction

  task automatic set_rec(input int i, input logic [RW-1:0] v);
    bus.src_record[i*RW +: RW] = v;
  endtask

  task automatic model_update();
    int          g;
    int unsigned hsz [NS];
    int unsigned osz;
    trace_entry_t e;
    if (rst) begin
      for (int i = 0; i < NS; i++) m_hold[i].delete();
      m_out.delete();
      m_rr  = NS - 1;
      m_raw = 0;
      m_ovf = 1'b0;
      return;
    end
    for (int i = 0; i < NS; i++) hsz[i] = m_hold[i].size();
    osz = m_out.size();
    g = -1;
    for (int k = 1; k <= NS; k++) begin
      if (g < 0 && hsz[(m_rr + k) % NS] > 0) g = (m_rr + k) % NS;
    end
    if (osz >= TBS) g = -1;
    if (osz > 0 && bus.trace_ready) void'(m_out.pop_front());
    if (g >= 0) begin
      m_out.push_back(m_hold[g].pop_front());
      m_rr = g;
    end
    if (bus.enable) begin
      for (int i = 0; i < NS; i++) begin
        if (bus.src_valid[i]) begin
          if (hsz[i] < HD || g == i) begin
            e.record    = bus.src_record[i*RW +: RW];
            e.source    = 1'(i);
            e.timestamp = bus.counter;
            m_hold[i].push_back(e);
          end else begin
            m_raw = m_raw + 1;
            m_ovf = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic logic [DW-1:0] exp_drop();
    return (m_raw > DMAX) ? DW'(DMAX) : DW'(m_raw);
  endfunction

  // One clock: model consumes the current inputs, DUT is sampled 1 time unit after the edge.
  task automatic step();
    bus.counter = cyc;
    model_update();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    bus.counter = cyc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.src_valid = '0;
    bus.enable = 1'b1;
    bus.trace_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.src_record = '0;
    do_reset();
    n_checks++; if (bus.trace_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.trace_valid); end
    n_checks++; if (bus.trace_record !== '0) begin n_fail++; $display("FAIL reset_record got=%h exp=0", bus.trace_record); end
    n_checks++; if (bus.trace_source !== '0) begin n_fail++; $display("FAIL reset_source got=%h exp=0", bus.trace_source); end
    n_checks++; if (bus.trace_time !== '0) begin n_fail++; $display("FAIL reset_time got=%h exp=0", bus.trace_time); end
    n_checks++; if (bus.drop_count !== '0) begin n_fail++; $display("FAIL reset_drop got=%h exp=0", bus.drop_count); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_single_pulse();
    do_reset();
    bus.trace_ready = 1'b1;
    cyc = 100;
    set_rec(0, 48'h0000_0013_0040);
    bus.src_valid = 2'b01;
    step();
    bus.src_valid = '0;
    n_checks++; if (bus.trace_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got=%b exp=0", bus.trace_valid); end
    step();
    n_checks++; if (bus.trace_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", bus.trace_valid); end
    n_checks++; if (bus.trace_record !== 48'h0000_0013_0040) begin n_fail++; $display("FAIL single_record got=%h exp=000000130040", bus.trace_record); end
    n_checks++; if (bus.trace_source !== 1'b0) begin n_fail++; $display("FAIL single_source got=%h exp=0", bus.trace_source); end
    n_checks++; if (bus.trace_time !== 32'd100) begin n_fail++; $display("FAIL single_time got=%0d exp=100", bus.trace_time); end
    step();
    n_checks++; if (bus.trace_valid !== 1'b0) begin n_fail++; $display("FAIL single_onebeat got=%b exp=0", bus.trace_valid); end
  endtask

  task automatic test_fairness();
    logic [RW-1:0] r0 [4];
    logic [RW-1:0] r1 [4];
    logic [RW-1:0] obs_rec [$];
    int            obs_src [$];
    logic [RW-1:0] er;
    do_reset();
    bus.trace_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c < 8 && c % 2 == 0) begin
        r0[c/2] = rand_rec();
        r1[c/2] = rand_rec();
        set_rec(0, r0[c/2]);
        set_rec(1, r1[c/2]);
        bus.src_valid = 2'b11;
      end else begin
        bus.src_valid = '0;
      end
      step();
      if (bus.trace_valid === 1'b1) begin
        obs_src.push_back(int'(bus.trace_source));
        obs_rec.push_back(bus.trace_record);
      end
    end
    n_checks++; if (obs_src.size() != 8) begin n_fail++; $display("FAIL fair_count got=%0d exp=8", obs_src.size()); end
    for (int k = 0; k < obs_src.size() && k < 8; k++) begin
      er = (k % 2 == 0) ? r0[k/2] : r1[k/2];
      n_checks++; if (obs_src[k] != k % 2) begin n_fail++; $display("FAIL fair_src[%0d] got=%0d exp=%0d", k, obs_src[k], k % 2); end
      n_checks++; if (obs_rec[k] !== er) begin n_fail++; $display("FAIL fair_rec[%0d] got=%h exp=%h", k, obs_rec[k], er); end
    end
    n_checks++; if (bus.drop_count !== '0) begin n_fail++; $display("FAIL fair_drop got=%0d exp=0", bus.drop_count); end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] rec [12];
    logic [31:0]   tim [12];
    logic [RW-1:0] obs_rec [$];
    logic [31:0]   obs_tim [$];
    do_reset();
    bus.trace_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      rec[c] = rand_rec();
      tim[c] = cyc;
      set_rec(0, rec[c]);
      bus.src_valid = 2'b01;
      step();
    end
    bus.src_valid = '0;
    n_checks++; if (bus.drop_count !== 16'd2) begin n_fail++; $display("FAIL bp_drop got=%0d exp=2", bus.drop_count); end
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf got=%b exp=1", bus.overflow); end
    n_checks++; if (bus.trace_record !== rec[0]) begin n_fail++; $display("FAIL bp_hold_head got=%h exp=%h", bus.trace_record, rec[0]); end
    bus.trace_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus.trace_valid === 1'b1) begin
        obs_rec.push_back(bus.trace_record);
        obs_tim.push_back(bus.trace_time);
      end
      step();
    end
    n_checks++; if (obs_rec.size() != 10) begin n_fail++; $display("FAIL bp_count got=%0d exp=10", obs_rec.size()); end
    for (int k = 0; k < obs_rec.size() && k < 10; k++) begin
      n_checks++; if (obs_rec[k] !== rec[k] || obs_tim[k] !== tim[k]) begin
        n_fail++; $display("FAIL bp_order[%0d] got=%h@%0d exp=%h@%0d", k, obs_rec[k], obs_tim[k], rec[k], tim[k]);
      end
    end
    n_checks++; if (bus.trace_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got=%b exp=0", bus.trace_valid); end
  endtask

  task automatic test_full_with_drain();
    logic [RW-1:0] rec [11];
    logic [RW-1:0] obs_rec [$];
    do_reset();
    bus.trace_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rec[c] = rand_rec();
      set_rec(1, rec[c]);
      bus.src_valid = 2'b10;
      step();
    end
    bus.src_valid = '0;
    n_checks++; if (bus.drop_count !== '0) begin n_fail++; $display("FAIL fwd_prefill_drop got=%0d exp=0", bus.drop_count); end
    bus.trace_ready = 1'b1;
    step();
    bus.trace_ready = 1'b0;
    rec[10] = rand_rec();
    set_rec(1, rec[10]);
    bus.src_valid = 2'b10;
    step();
    bus.src_valid = '0;
    n_checks++; if (bus.drop_count !== '0) begin n_fail++; $display("FAIL fwd_drop got=%0d exp=0", bus.drop_count); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fwd_ovf got=%b exp=0", bus.overflow); end
    bus.trace_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (bus.trace_valid === 1'b1) obs_rec.push_back(bus.trace_record);
      step();
    end
    n_checks++; if (obs_rec.size() != 10) begin n_fail++; $display("FAIL fwd_count got=%0d exp=10", obs_rec.size()); end
    for (int k = 0; k < obs_rec.size() && k < 10; k++) begin
      n_checks++; if (obs_rec[k] !== rec[k+1]) begin n_fail++; $display("FAIL fwd_order[%0d] got=%h exp=%h", k, obs_rec[k], rec[k+1]); end
    end
  endtask

  task automatic test_enable();
    do_reset();
    bus.trace_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      set_rec(0, rand_rec());
      bus.src_valid = 2'b01;
      step();
    end
    bus.enable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.src_valid = 2'b11;
      step();
    end
    bus.src_valid = '0;
    bus.enable = 1'b1;
    n_checks++; if (bus.drop_count !== '0) begin n_fail++; $display("FAIL en_full_drop got=%0d exp=0", bus.drop_count); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL en_full_ovf got=%b exp=0", bus.overflow); end
    do_reset();
    bus.trace_ready = 1'b1;
    bus.enable = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.src_valid = (c < 4) ? 2'b11 : 2'b00;
      step();
      n_checks++; if (bus.trace_valid !== 1'b0) begin n_fail++; $display("FAIL en_idle[%0d] got=%b exp=0", c, bus.trace_valid); end
    end
    bus.src_valid = '0;
    bus.enable = 1'b1;
  endtask

  task automatic test_saturation();
    int  budget;
    logic [DW-1:0] ed;
    do_reset();
    bus.trace_ready = 1'b0;
    bus.src_valid = 2'b11;
    budget = 0;
    while (m_raw < 65539 && budget < 40000) begin
      set_rec(0, rand_rec());
      set_rec(1, rand_rec());
      step();
      budget++;
      ed = exp_drop();
      n_checks++; if (bus.drop_count !== ed) begin n_fail++; $display("FAIL sat_track cyc=%0d got=%0d exp=%0d", cyc, bus.drop_count, ed); end
    end
    n_checks++; if (budget >= 40000) begin n_fail++; $display("FAIL sat_timeout got=%0d cycles exp<40000", budget); end
    n_checks++; if (bus.drop_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_value got=%h exp=ffff", bus.drop_count); end
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL sat_ovf got=%b exp=1", bus.overflow); end
  endtask

  // Runs straight after saturation so the buffers are full and drop_count is non-zero.
  task automatic test_reset_midstream();
    rst = 1'b1;
    bus.src_valid = 2'b11;
    step();
    rst = 1'b0;
    bus.src_valid = '0;
    bus.trace_ready = 1'b1;
    n_checks++; if (bus.trace_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%b exp=0", bus.trace_valid); end
    n_checks++; if (bus.drop_count !== '0) begin n_fail++; $display("FAIL mid_drop got=%0d exp=0", bus.drop_count); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf got=%b exp=0", bus.overflow); end
    step();
    n_checks++; if (bus.trace_valid !== 1'b0) begin n_fail++; $display("FAIL mid_partial got=%b exp=0", bus.trace_valid); end
    set_rec(0, rand_rec());
    set_rec(1, rand_rec());
    bus.src_valid = 2'b11;
    step();
    bus.src_valid = '0;
    step();
    n_checks++; if (bus.trace_valid !== 1'b1 || bus.trace_source !== 1'b0) begin
      n_fail++; $display("FAIL mid_first got=v%b/s%0d exp=v1/s0", bus.trace_valid, bus.trace_source);
    end
    step();
    n_checks++; if (bus.trace_valid !== 1'b1 || bus.trace_source !== 1'b1) begin
      n_fail++; $display("FAIL mid_second got=v%b/s%0d exp=v1/s1", bus.trace_valid, bus.trace_source);
    end
  endtask

  task automatic test_random();
    trace_entry_t got;
    logic [DW-1:0] ed;
    bit ev;
    do_reset();
    cyc = 32'hFFFF_FF00;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      bus.enable = ($urandom_range(0, 9) != 0);
      bus.src_valid = NS'($urandom());
      set_rec(0, rand_rec());
      set_rec(1, rand_rec());
      bus.trace_ready = ($urandom_range(0, 9) < 6);
      step();
      ev = (m_out.size() > 0);
      n_checks++; if (bus.trace_valid !== ev) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.trace_valid, ev); end
      if (ev) begin
        got = {bus.trace_record, bus.trace_source, bus.trace_time};
        n_checks++; if (got !== m_out[0]) begin n_fail++; $display("FAIL rnd_head c=%0d got=%h exp=%h", c, got, m_out[0]); end
      end
      ed = exp_drop();
      n_checks++; if (bus.drop_count !== ed) begin n_fail++; $display("FAIL rnd_drop c=%0d got=%0d exp=%0d", c, bus.drop_count, ed); end
      n_checks++; if (bus.overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, bus.overflow, m_ovf); end
    end
    rst = 1'b0;
    bus.src_valid = '0;
    bus.enable = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    bus.counter = '0;
    bus.enable = 1'b1;
    bus.src_valid = '0;
    bus.src_record = '0;
    bus.trace_ready = 1'b0;
    m_rr = NS - 1;
    m_raw = 0;
    m_ovf = 1'b0;
    test_reset();
    test_single_pulse();
    test_fairness();
    test_backpressure();
    test_full_with_drain();
    test_enable();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
